avg_stream_ctrl: RTL

Front-end sequencer for the 16-bit moving-average core (avg: din, reset, clk -> ready, dout). Accepts bursty upstream samples over a valid/ready handshake and buffers them in a small FIFO. Runs the core in frames: reset pulse, prime, one sample per cycle with no stall, then drain. Forwards core results downstream with a per-frame completion strobe and an underrun flag.

---
 rtl/avg_pkg.sv | 27 ++
 rtl/avg_fifo.sv | 75 +++++++
 rtl/avg_stream_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/avg_pkg.sv
// avg_pkg: shared types and constants for the moving-average stream front end.
//   SAMPLE_W - width of a sample travelling to and from the averaging core
//   LEN_W    - width of frame_len and of the per-frame sample counter
//   state_t  - controller FSM states
//   min_len  - smaller of two frame-length-sized values
package avg_pkg;

    localparam int SAMPLE_W = 16;
    localparam int LEN_W    = 12;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [LEN_W-1:0]    len_t;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        PRIME,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    function automatic len_t min_len(input len_t a, input len_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/avg_fifo.sv
// avg_fifo: DEPTH x SAMPLE_W synchronous FIFO with show-ahead head output.
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset; empties the FIFO
//   push  - write din this cycle (ignored when full unless popping too)
//   din   - sample to write
//   pop   - remove head this cycle (ignored when empty unless pushing too)
//   head  - oldest sample; bypasses din when empty so push+pop passes through
//   count - number of stored samples, 0..DEPTH
//   full  - count == DEPTH
//   empty - count == 0
module avg_fifo
    import avg_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  sample_t                din,
    input  logic                   pop,
    output sample_t                head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    sample_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A push on a full FIFO fits when the head leaves in the same cycle; a pop
    // on an empty FIFO is served by the bypass below. Either way count holds.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && (!empty || push);

    assign head = empty ? din : mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count alone decide which entries are valid, so clearing data is wasted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/avg_stream_ctrl.sv
// avg_stream_ctrl: frames a bursty sample stream into the moving-average core.
// Each frame: pulse the core reset, wait for the FIFO to prime, feed one
// sample per cycle (holding the last sample if the FIFO runs dry), drain the
// core for a fixed time, then pulse frame_done.
//   clk, reset          - clock; asynchronous active-high reset
//   start, frame_len    - begin a frame of frame_len samples (IDLE only)
//   in_valid, in_data   - upstream sample; in_ready = FIFO not full
//   avg_reset, avg_din  - core reset and registered core input sample
//   avg_ready, avg_dout - core result strobe and value
//   out_valid, out_data - core result, registered, forwarded in STREAM/DRAIN
//   frame_done          - one-cycle end-of-frame pulse
//   busy                - controller not IDLE
//   underrun            - sticky: FIFO empty during STREAM; cleared on start
module avg_stream_ctrl
    import avg_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int RST_CYC   = 2,
    parameter int PRIME_LVL = 8,
    parameter int DRAIN_CYC = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] frame_len,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        avg_reset,
    output logic [15:0] avg_din,
    input  logic        avg_ready,
    input  logic [15:0] avg_dout,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        frame_done,
    output logic        busy,
    output logic        underrun
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int RC_W  = $clog2(RST_CYC + 1);
    localparam int DC_W  = $clog2(DRAIN_CYC + 1);

    state_t            state;
    state_t            next_state;
    len_t              len_q;
    len_t              sent;
    len_t              prime_lvl;
    logic [RC_W-1:0]   rst_cnt;
    logic [DC_W-1:0]   drain_cnt;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    sample_t           head;
    logic [CNT_W-1:0]  fifo_count;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    // Short frames never reach PRIME_LVL, so prime on the whole frame instead.
    assign prime_lvl = min_len(len_t'(PRIME_LVL), len_q);

    avg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (in_data),
        .pop   (pop),
        .head  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (frame_len == '0) ? DONE : RST;
                end
            end
            RST: begin
                if (rst_cnt == RC_W'(RST_CYC - 1)) begin
                    next_state = PRIME;
                end
            end
            PRIME: begin
                if (len_t'(fifo_count) >= prime_lvl) begin
                    next_state = STREAM;
                end
            end
            STREAM: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (sent + len_t'(1) == len_q) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == DC_W'(DRAIN_CYC - 1)) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign avg_reset  = (state == RST);
    assign frame_done = (state == DONE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q     <= '0;
            sent      <= '0;
            rst_cnt   <= '0;
            drain_cnt <= '0;
            underrun  <= 1'b0;
            avg_din   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q     <= frame_len;
                        sent      <= '0;
                        rst_cnt   <= '0;
                        drain_cnt <= '0;
                        underrun  <= 1'b0;
                        avg_din   <= '0;
                    end
                end
                RST: begin
                    rst_cnt <= rst_cnt + RC_W'(1);
                end
                STREAM: begin
                    out_valid <= avg_ready;
                    out_data  <= avg_dout;
                    // The core has no stall: on an empty FIFO it re-consumes
                    // the held sample, which is what underrun records.
                    if (pop) begin
                        avg_din <= head;
                        sent    <= sent + len_t'(1);
                    end else begin
                        underrun <= 1'b1;
                    end
                end
                DRAIN: begin
                    out_valid <= avg_ready;
                    out_data  <= avg_dout;
                    drain_cnt <= drain_cnt + DC_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
